// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one fetch at a time over a req/gnt/rvalid
// handshake and hands instructions to decode through a one-entry buffer.
//
//   state | meaning
//   IDLE  | first cycle after reset, no request
//   REQ   | request at pc while the buffer has room (or drains this cycle)
//   WAIT  | one request outstanding, waiting for rvalid
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        valid_d;
  logic [31:0] out_d, ipc_d;
  logic        fire, redirect;
  logic [31:0] target;

  assign mem_addr = pc_q;
  assign target   = redirect_target & 32'hFFFF_FFFC;
  assign redirect = redirect_valid && (state_q != IDLE);
  assign mem_req  = (state_q == REQ) && (!instr_valid || !stall);
  assign fire     = mem_req && mem_gnt;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    valid_d   = instr_valid;
    out_d     = instr_out;
    ipc_d     = instr_pc;

    if (instr_valid && !stall) valid_d = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (fire) begin
          state_d = WAIT;
          // request for the old pc is already on its way back
          if (redirect) discard_d = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = REQ;
          if (discard_q) begin
            discard_d = 1'b0;
          end else if (!redirect) begin
            valid_d = 1'b1;
            out_d   = mem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + 32'd4;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // redirect flushes the buffer even if decode is stalled
    if (redirect) begin
      pc_d    = target;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= 32'h0;
      instr_pc    <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      instr_valid <= valid_d;
      instr_out   <= out_d;
      instr_pc    <= ipc_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random stall/gnt/latency/redirect
// traffic, checked against a program-order model of the instruction stream.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_v, sel;
  logic        rst_a, rst_b;
  logic        mem_gnt, mem_rvalid, redirect_valid, stall;
  logic [31:0] mem_rdata, redirect_target;
  logic        a_req, b_req, a_iv, b_iv;
  logic [31:0] a_addr, b_addr, a_out, b_out, a_ipc, b_ipc;
  logic        mem_req, instr_valid;
  logic [31:0] mem_addr, instr_out, instr_pc;

  // the unselected DUT is held in reset
  assign rst_a       = reset_v | sel;
  assign rst_b       = reset_v | ~sel;
  assign mem_req     = sel ? b_req  : a_req;
  assign mem_addr    = sel ? b_addr : a_addr;
  assign instr_valid = sel ? b_iv   : a_iv;
  assign instr_out   = sel ? b_out  : a_out;
  assign instr_pc    = sel ? b_ipc  : a_ipc;

  fetch_sequencer u_dut_a (
    .clk(clk), .reset(rst_a), .mem_req(a_req), .mem_addr(a_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .stall(stall), .instr_valid(a_iv),
    .instr_out(a_out), .instr_pc(a_ipc)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8)) u_dut_b (
    .clk(clk), .reset(rst_b), .mem_req(b_req), .mem_addr(b_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .stall(stall), .instr_valid(b_iv),
    .instr_out(b_out), .instr_pc(b_ipc)
  );

  int n_chk, n_pass, n_pres;
  // memory model
  logic        pend;
  logic [31:0] paddr;
  int          cnt;
  // program-order model: pc of the next instruction decode must see
  logic [31:0] exp_pc;
  // per-step configuration
  logic        cfg_stall, cfg_gnt;
  int          cfg_lat, redir_mode;
  logic [31:0] redir_match, redir_tgt;
  // values observed just before the edge
  logic        o_req, o_iv, o_rvalid, o_redir, o_fire;
  logic [31:0] o_addr, o_ipc, o_iout;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] rpc();
    return sel ? 32'hFFFF_FFF8 : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    stall           = cfg_stall;
    mem_gnt         = cfg_gnt;
    mem_rvalid      = pend && (cnt == 0);
    mem_rdata       = mem_rvalid ? memf(paddr) : $urandom;
    redirect_valid  = 1'b0;
    redirect_target = $urandom;
    #1;
    o_req = mem_req; o_addr = mem_addr; o_iv = instr_valid; o_ipc = instr_pc;
    o_iout = instr_out; o_rvalid = mem_rvalid; o_fire = mem_req && mem_gnt;
    o_redir = (redir_mode == 1) || (redir_mode == 2 && o_fire && o_addr == redir_match)
              || (redir_mode == 3 && o_rvalid);
    if (o_redir) begin
      redirect_valid  = 1'b1;
      redirect_target = redir_tgt;
      redir_mode      = 0;
    end
    if (!reset_v) begin
      if (o_iv) begin
        chk("instr_pc", o_ipc, exp_pc);
        chk("instr_out", o_iout, memf(exp_pc));
      end
      if (o_iv && cfg_stall) chk("req_during_stall", {31'b0, o_req}, 32'd0);
      if (pend) chk("one_outstanding", {31'b0, o_req}, 32'd0);
      if (o_fire && !o_redir) chk("fetch_addr", o_addr, o_iv ? exp_pc + 32'd4 : exp_pc);
    end
    @(posedge clk);
    #1;
    if (reset_v) begin
      pend   = 1'b0;
      exp_pc = rpc();
    end else begin
      if (o_fire) begin
        pend = 1'b1; paddr = o_addr; cnt = cfg_lat;
      end else if (o_rvalid) begin
        pend = 1'b0;
      end else if (pend && cnt > 0) begin
        cnt--;
      end
      if (o_redir) exp_pc = redir_tgt & 32'hFFFF_FFFC;
      else if (o_iv && !cfg_stall) begin
        exp_pc += 32'd4;
        n_pres++;
      end
    end
  endtask

  task automatic run_until_grant(input string tag, output logic [31:0] a);
    bit found = 1'b0;
    a = 32'hDEAD_BEEF;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (o_fire) begin a = o_addr; found = 1'b1; end
    end
    if (!found) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_until_valid(input string tag, output logic [31:0] p);
    bit found = 1'b0;
    p = 32'hDEAD_BEEF;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (o_iv) begin p = o_ipc; found = 1'b1; end
    end
    if (!found) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset_v = 1'b1;
    step();
    reset_v = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    bit          found;
    n_chk = 0; n_pass = 0; n_pres = 0;
    sel = 1'b0; reset_v = 1'b1; pend = 1'b0; cnt = 0; paddr = 0; exp_pc = 0;
    cfg_stall = 1'b0; cfg_gnt = 1'b1; cfg_lat = 0; redir_mode = 0;
    redir_match = 0; redir_tgt = 0;
    stall = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    redirect_valid = 0; redirect_target = 0;

    // reset values, then zero-wait streaming
    step(); step();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    reset_v = 1'b0;
    step();
    chk("idle_req", {31'b0, o_req}, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("stream_valid", {31'b0, o_iv}, {31'b0, (i == 3 || i == 5)});
    end

    // stall held while pc 8 is buffered
    cfg_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'b0, o_iv}, 32'd1);
      chk("stall_pc", o_ipc, 32'h8);
      chk("stall_req", {31'b0, o_req}, 32'd0);
    end
    cfg_stall = 1'b0;
    step(); step(); step();
    chk("after_stall_valid", {31'b0, o_iv}, 32'd1);
    chk("after_stall_pc", o_ipc, 32'hC);

    // latency 3, redirect in the cycle after the grant for pc 4
    do_reset();
    cfg_lat = 2;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (o_fire && o_addr == 32'h4) found = 1'b1;
    end
    chk("grant4_seen", {31'b0, found}, 32'd1);
    redir_mode = 1; redir_tgt = 32'h100;
    step();
    run_until_grant("redir_wait_grant", a);
    chk("redir_wait_addr", a, 32'h100);
    run_until_valid("redir_wait_valid", a);
    chk("redir_wait_pc", a, 32'h100);

    // redirect coincident with the grant for pc 8
    do_reset();
    cfg_lat = 0;
    redir_mode = 2; redir_match = 32'h8; redir_tgt = 32'h203;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      found = o_redir;
    end
    chk("redir_gnt_seen", {31'b0, found}, 32'd1);
    chk("redir_gnt_flush", {31'b0, instr_valid}, 32'd0);
    run_until_grant("redir_gnt_grant", a);
    chk("redir_gnt_addr", a, 32'h200);
    run_until_valid("redir_gnt_valid", a);
    chk("redir_gnt_pc", a, 32'h200);

    // redirect coincident with rvalid: no extra discard, exact timing
    do_reset();
    redir_mode = 3; redir_tgt = 32'h300;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      found = o_redir;
    end
    chk("redir_rv_seen", {31'b0, found}, 32'd1);
    step();
    chk("redir_rv_req", {31'b0, o_fire}, 32'd1);
    chk("redir_rv_addr", o_addr, 32'h300);
    step(); step();
    chk("redir_rv_valid", {31'b0, o_iv}, 32'd1);
    chk("redir_rv_pc", o_ipc, 32'h300);

    // random traffic against the program-order model
    do_reset();
    n_pres = 0;
    for (int i = 0; i < 1500; i++) begin
      cfg_stall = ($urandom_range(0, 9) < 3);
      cfg_gnt   = ($urandom_range(0, 9) < 6);
      cfg_lat   = $urandom_range(0, 3);
      if (i >= 2 && redir_mode == 0 && $urandom_range(0, 29) == 0) begin
        redir_mode = ($urandom_range(0, 1) == 0) ? 1 : 3;
        redir_tgt  = $urandom;
      end
      step();
    end
    chk("random_progress", {31'b0, (n_pres >= 50)}, 32'd1);

    // RESET_PC near the top of the address space: wrap, then reset mid-WAIT
    redir_mode = 0; cfg_stall = 1'b0; cfg_gnt = 1'b1; cfg_lat = 0;
    sel = 1'b1;
    do_reset();
    chk("wrap_rst_addr", mem_addr, 32'hFFFF_FFF8);
    run_until_grant("wrap_g0", a);
    chk("wrap_addr0", a, 32'hFFFF_FFF8);
    run_until_grant("wrap_g1", a);
    chk("wrap_addr1", a, 32'hFFFF_FFFC);
    run_until_grant("wrap_g2", a);
    chk("wrap_addr2", a, 32'h0000_0000);
    do_reset();
    chk("wait_rst_req", {31'b0, mem_req}, 32'd0);
    chk("wait_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("wait_rst_addr", mem_addr, 32'hFFFF_FFF8);
    step();
    chk("wait_rst_idle_req", {31'b0, o_req}, 32'd0);
    step();
    chk("wait_rst_req1", {31'b0, o_req}, 32'd1);
    chk("wait_rst_addr1", o_addr, 32'hFFFF_FFF8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetches over a req/gnt/rvalid memory handshake that has variable latency.
- Presents fetched instructions to decode through a one-entry output buffer with a stall input.
- Handles redirects (taken branch, jal, jalr) from execute, including discarding a stale in-flight response.
- Sits between instruction memory and decode, replacing the free-running PC register.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset. Must be 4-byte aligned.

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- mem_req  out  1  fetch request valid
- mem_addr  out  32  fetch address; always equals the current PC
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response data valid
- mem_rdata  in  32  response instruction word
- redirect_valid  in  1  one-cycle pulse: PC redirect from execute
- redirect_target  in  32  new PC; bits [1:0] are ignored and forced to 00
- stall  in  1  decode cannot accept the instruction this cycle
- instr_valid  out  1  output buffer holds a valid instruction
- instr_out  out  32  buffered instruction word
- instr_pc  out  32  PC of instr_out

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, discard=0. Reset asserted mid-transaction abandons the transaction. Any later rvalid for that transaction is not expected by the memory and is not handled.
- States:
  - IDLE: entered only from reset. Goes to REQ on the next cycle.
  - REQ: mem_req = !instr_valid || !stall. On mem_req && mem_gnt, go to WAIT.
  - WAIT: mem_req=0. Wait for mem_rvalid, then return to REQ.
- At most one outstanding request.
- Before gnt, mem_req may drop and mem_addr may change (this happens on a stall or redirect). The memory must tolerate this.
- Response handling in WAIT, on mem_rvalid:
  - If discard=1: drop the data, clear discard, buffer unchanged.
  - Otherwise: instr_out<=mem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
- Dequeue: if instr_valid && !stall at an edge, the entry is consumed and instr_valid<=0 (unless refilled by a response in the same cycle).
- While stall=1 and instr_valid=1: the buffer holds; instr_out and instr_pc are stable.
- Fetch-to-use latency: the first instruction is visible when instr_valid=1 one cycle after the rvalid cycle. With a zero-wait memory (gnt in the req cycle, rvalid the next cycle), sustained throughput is one instruction per 2 cycles.
- Redirect, when redirect_valid=1 in any state except IDLE:
  - pc<=redirect_target&~3 and instr_valid<=0 at the same edge. A stall is overridden.
  - In WAIT without rvalid this cycle: discard<=1.
  - In REQ with mem_gnt this cycle: discard<=1 and go to WAIT. The old-address request is in flight.
  - In REQ without gnt: the next cycle issues the new address.
  - In WAIT with mem_rvalid in the same cycle: the response is dropped, discard stays 0, and the state goes to REQ.
  - A redirect in the same cycle as reset is ignored. Reset wins.
- A second redirect while discard=1 updates pc only. discard stays 1 because only one response is pending.
- mem_addr is driven combinationally from the pc register.

Test Plan:
- Reset then zero-wait memory returning rdata=PC^32'hA5A5_0000, stall=0: instr_pc sequence 0,4,8,C, with instr_valid high every other cycle. mem_req=0 during reset and in the first post-reset cycle.
- Stall held 5 cycles while instr_pc=8: instr_out and instr_pc stable, mem_req=0 for the whole stall. No PC skip or duplicate after release (next instr_pc=C).
- Memory latency 3 cycles: redirect_target=32'h100 pulsed in the cycle after gnt for PC=4. The returning data is discarded and not presented. The next request has mem_addr=0x100, and instr_pc=0x100 is presented.
- redirect_valid coincident with mem_gnt for PC=8 (target 32'h203): data for 8 is discarded, the next fetch is at 0x200, and instr_valid=0 after the redirect edge.
- redirect_valid coincident with mem_rvalid in WAIT: the response is dropped, there is no extra discard, and the next presented instruction has instr_pc equal to the target.
- RESET_PC=32'hFFFF_FFF8: fetches at FFFF_FFF8, FFFF_FFFC, then 0000_0000 (wrap). Reset asserted while in WAIT: returns to IDLE with pc=RESET_PC and instr_valid=0.
